segment_scan_driver: RTL and testbench
======================================

Name: segment_scan_driver

Overview:
- Downstream stage of the SegmentLed AXI4-Lite slave register file.
- Takes the digit, decimal-point, enable and brightness values written over AXI.
- Drives a multiplexed common-anode 7-segment display: time-sliced anode scan, hex-to-segment decode, anti-ghost blank phase and PWM brightness.
- Register values are double-buffered in shadow registers. New values take effect only at frame boundaries, so a partially written display is never shown.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 1..8.
- CLK_DIV, 100000: ACLK cycles per digit slot; must be a multiple of 16 and at least 32.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp lit when driven 0.
- AN_ACTIVE_LOW, 1: 1 = digit anode selected when driven 0.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  asynchronous active-low reset.
- digits_i  in  32  nibble per digit; digit i = digits_i[4i+3:4i].
- dp_i  in  8  decimal point per digit (1 = lit).
- digit_en_i  in  8  per-digit enable (1 = shown).
- enable_i  in  1  global display enable.
- brightness_i  in  4  on-phases per slot, 0..15.
- update_i  in  1  single-cycle request to load shadow registers.
- update_ack_o  out  1  single-cycle pulse when shadow registers load.
- seg_o  out  7  segments; seg_o[0]=a … seg_o[6]=g.
- dp_o  out  1  decimal point.
- an_o  out  NUM_DIGITS  anode selects.
- frame_o  out  1  single-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset (asynchronous, ARESETN=0):
  - All counters, digit index and pending flag = 0.
  - Shadow registers = 0.
  - seg_o/dp_o/an_o at inactive level: all 1s if active-low, all 0s otherwise.
  - update_ack_o = 0, frame_o = 0.
- Counters:
  - tick_cnt counts 0..CLK_DIV/16-1.
  - phase increments 0..15 on tick_cnt wrap.
  - digit index increments 0..NUM_DIGITS-1 on phase wrap, then wraps to 0.
  - Frame length = NUM_DIGITS*CLK_DIV cycles.
- Frame end = cycle with digit=NUM_DIGITS-1, phase=15, tick_cnt=max. frame_o is asserted on that cycle.
- States:
  - IDLE (enable_i=0): counters held at 0; outputs inactive; frame_o=0.
  - SCAN (enable_i=1): counters run.
  - IDLE→SCAN when enable_i rises; first slot is digit 0, phase 0.
  - SCAN→IDLE on the cycle after enable_i falls, mid-frame or not; counters clear.
- Lit condition: digit d is lit in phase p iff shadow digit_en[d]=1 and 1 <= p <= shadow brightness.
  - Phase 0 is always blank (anti-ghost).
  - brightness 0 = dark; brightness 15 = 15/16 duty.
  - Disabled digits still consume their slot time.
- When lit:
  - an_o selects only bit d.
  - seg_o = decode(shadow nibble d).
  - dp_o = shadow dp[d].
  - Otherwise all three are inactive.
  - All outputs are registered: they reflect the counter state one cycle earlier.
- Decode, active-high {g..a}: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71. Inverted when SEG_ACTIVE_LOW=1.
- Update handshake:
  - update_i sets pending.
  - In SCAN, the shadow registers load all inputs on the frame-end cycle. update_ack_o pulses on the next cycle and pending clears.
  - In IDLE, the load happens the cycle after update_i; ack pulses the cycle after that.
  - update_i on the frame-end cycle itself loads at that same boundary.
  - update_i while pending is already set: no extra ack; the latest input values at load time are used.
  - enable_i falling while pending: the load proceeds per the IDLE rule on the next cycle.
- brightness_i, dp_i, digit_en_i and digits_i never affect outputs except through the shadow registers.

Test Plan:
(Bench config: NUM_DIGITS=4, CLK_DIV=32, both active-low. Tick=2 cycles, slot=32, frame=128.)
1. Reset then idle: ARESETN low 200 ns, enable_i=0 → seg_o=7F, dp_o=1, an_o=F, frame_o never pulses.
2. Basic scan:
   - Stimulus: enable_i=0, digits_i=0x00004321, digit_en_i=0F, dp_i=0, brightness_i=15, update_i pulse; then enable_i=1.
   - Required: update_ack_o pulses once while in IDLE.
   - Digit 0 slot: an_o=E, seg_o=~06=79 for phases 1..15; phase 0 (2 cycles) shows an_o=F.
   - Digits 1/2/3 show seg_o 24/30/19.
   - frame_o pulses every 128 cycles.
3. Brightness PWM: brightness=4 loaded → per 32-cycle slot, 8 cycles lit (phases 1..4) and 24 cycles dark. brightness=0 → an_o constantly F.
4. Frame-boundary update:
   - Stimulus: mid-frame update_i with digits_i=0x0000FFFF.
   - Required: old digits keep displaying until frame_o; update_ack_o pulses the next cycle; next frame shows seg_o=0E on all digits.
   - A second update_i while pending produces exactly one ack.
5. Masking and dp: digit_en_i=05, dp_i=02 → only slots 0 and 2 drive anodes; dp_o stays 1 (off) because digit 1 is masked; slots 1 and 3 keep their 32-cycle duration.
6. Disable and reset mid-frame:
   - enable_i low mid-slot → outputs inactive from the next cycle; re-enable restarts at digit 0, phase 0.
   - ARESETN asserted mid-scan → outputs inactive immediately, with no clock edge required.

Source files
------------

// File: rtl/segment_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver: anode time slicing, hex decode,
// anti-ghost blank phase, PWM brightness and frame-synchronous shadow registers.
`timescale 1ns/1ps

module segment_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [31:0]           digits_i,
  input  logic [7:0]            dp_i,
  input  logic [7:0]            digit_en_i,
  input  logic                  enable_i,
  input  logic [3:0]            brightness_i,
  input  logic                  update_i,
  output logic                  update_ack_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  localparam int TICKS  = CLK_DIV / 16;
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  localparam logic [TICK_W-1:0]     TICK_MAX   = TICK_W'(TICKS - 1);
  localparam logic [2:0]            LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        phase_q, phase_d;
  logic [2:0]        digit_q, digit_d;
  logic              pending_q, pending_d;

  logic [31:0] sh_digits_q;
  logic [7:0]  sh_dp_q;
  logic [7:0]  sh_en_q;
  logic [3:0]  sh_bright_q;

  logic                  frame_end;
  logic                  frame_d;
  logic                  load;
  logic                  lit;
  logic [3:0]            nibble;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    return pattern;
  endfunction

  // Dropping enable_i forces IDLE on the very next edge, mid-frame or not.
  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    state_d = enable_i ? ST_SCAN : ST_IDLE;
    tick_d  = '0;
    phase_d = '0;
    digit_d = '0;
    if (enable_i && (state_q == ST_SCAN)) begin
      tick_d  = tick_q;
      phase_d = phase_q;
      digit_d = digit_q;
      if (tick_q == TICK_MAX) begin
        tick_d  = '0;
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'd15) begin
          digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  assign frame_end = (state_q == ST_SCAN) && (tick_q == TICK_MAX) &&
                     (phase_q == 4'd15) && (digit_q == LAST_DIGIT);

  // Registered so frame_o is high exactly while the counters sit on the last cycle.
  assign frame_d = (state_d == ST_SCAN) && (tick_d == TICK_MAX) &&
                   (phase_d == 4'd15) && (digit_d == LAST_DIGIT);

  // While scanning, a request arriving on the frame-end cycle still makes that boundary.
  always_comb begin
    load = 1'b0;
    if (state_q == ST_IDLE) begin
      load = pending_q;
    end else begin
      load = frame_end && (pending_q || update_i);
    end
    pending_d = load ? 1'b0 : (pending_q || update_i);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      phase_q   <= '0;
      digit_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      digit_q   <= digit_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      // NOTE: shadow registers are reset so the first enabled frame is defined (all digits dark).
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      sh_bright_q <= '0;
    end else if (load) begin
      sh_digits_q <= digits_i;
      sh_dp_q     <= dp_i;
      sh_en_q     <= digit_en_i;
      sh_bright_q <= brightness_i;
    end
  end

  // Phase 0 of every slot stays blank so the anode switch never shows the previous digit.
  assign lit = enable_i && (state_q == ST_SCAN) && sh_en_q[digit_q] &&
               (phase_q != 4'd0) && (phase_q <= sh_bright_q);

  assign nibble = sh_digits_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (lit) begin
      seg_d = hex_to_seg(nibble) ^ SEG_OFF;
      dp_d  = sh_dp_q[digit_q] ^ DP_OFF;
      an_d  = (NUM_DIGITS'(1) << digit_q) ^ AN_OFF;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      seg_o        <= SEG_OFF;
      dp_o         <= DP_OFF;
      an_o         <= AN_OFF;
      update_ack_o <= 1'b0;
      frame_o      <= 1'b0;
    end else begin
      seg_o        <= seg_d;
      dp_o         <= dp_d;
      an_o         <= an_d;
      update_ack_o <= load;
      frame_o      <= frame_d;
    end
  end

endmodule

// File: tb/tb_segment_scan_driver.sv
// Directed bench for segment_scan_driver: 4 digits, CLK_DIV=32 (slot 32, frame 128 cycles),
// active-low segments and anodes. Cycle k of a scan shows the counter state of cycle k-1.
`timescale 1ns/1ps

module tb_segment_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [31:0] digits_i;
  logic [7:0]  dp_i;
  logic [7:0]  digit_en_i;
  logic        enable_i;
  logic [3:0]  brightness_i;
  logic        update_i;
  logic        update_ack_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int total;
  int bad;
  int cyc_n;
  int frame_cnt;
  int ack_cnt;
  int dp_lit;
  int hist [16];
  int base;

  segment_scan_driver #(
    .NUM_DIGITS    (4),
    .CLK_DIV       (32),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .digits_i    (digits_i),
    .dp_i        (dp_i),
    .digit_en_i  (digit_en_i),
    .enable_i    (enable_i),
    .brightness_i(brightness_i),
    .update_i    (update_i),
    .update_ack_o(update_ack_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .an_o        (an_o),
    .frame_o     (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_stats();
    frame_cnt = 0;
    ack_cnt   = 0;
    dp_lit    = 0;
    for (int i = 0; i < 16; i++) hist[i] = 0;
  endtask

  // Advance to cycle k, sampling 1 ns after each rising edge.
  task automatic run_to(input int k);
    while (cyc_n < k) begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (frame_o) frame_cnt++;
      if (update_ack_o) ack_cnt++;
      hist[an_o]++;
      if (!dp_o) dp_lit++;
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    cyc_n        = 0;
    rst_n        = 1'b0;
    digits_i     = '0;
    dp_i         = '0;
    digit_en_i   = '0;
    enable_i     = 1'b0;
    brightness_i = '0;
    update_i     = 1'b0;
    clear_stats();

    // 1. reset then idle
    #200;
    check("rst_seg", seg_o, 32'h7F);
    check("rst_dp", dp_o, 32'h1);
    check("rst_an", an_o, 32'hF);
    check("rst_frame", frame_o, 32'h0);
    check("rst_ack", update_ack_o, 32'h0);
    rst_n = 1'b1;
    run_to(40);
    check("idle_frames", frame_cnt, 32'd0);
    check("idle_an_dark", hist[15], 32'd40);
    check("idle_seg", seg_o, 32'h7F);

    // 2. load in IDLE, then scan
    clear_stats();
    digits_i     = 32'h0000_4321;
    digit_en_i   = 8'h0F;
    dp_i         = 8'h00;
    brightness_i = 4'd15;
    update_i     = 1'b1;
    run_to(41);
    update_i = 1'b0;
    check("idle_ack_early", update_ack_o, 32'h0);
    run_to(42);
    check("idle_ack", update_ack_o, 32'h1);
    run_to(43);
    check("idle_ack_once", ack_cnt, 32'd1);
    check("idle_still_dark", an_o, 32'hF);

    enable_i = 1'b1;
    cyc_n    = -1;
    clear_stats();
    run_to(0);
    check("scan_c0_an", an_o, 32'hF);
    run_to(2);
    check("scan_ph0_an", an_o, 32'hF);
    run_to(3);
    check("d0_an", an_o, 32'hE);
    check("d0_seg", seg_o, 32'h79);
    check("d0_dp", dp_o, 32'h1);
    run_to(32);
    check("d0_last_an", an_o, 32'hE);
    run_to(33);
    check("d1_ph0_an", an_o, 32'hF);
    run_to(35);
    check("d1_an", an_o, 32'hD);
    check("d1_seg", seg_o, 32'h24);
    run_to(67);
    check("d2_an", an_o, 32'hB);
    check("d2_seg", seg_o, 32'h30);
    run_to(99);
    check("d3_an", an_o, 32'h7);
    check("d3_seg", seg_o, 32'h19);
    run_to(126);
    check("frame_early", frame_o, 32'h0);
    run_to(127);
    check("frame_1", frame_o, 32'h1);
    run_to(255);
    check("frame_2", frame_o, 32'h1);
    check("frame_cnt", frame_cnt, 32'd2);

    // 3. brightness PWM
    run_to(260);
    brightness_i = 4'd4;
    update_i     = 1'b1;
    run_to(261);
    update_i = 1'b0;
    run_to(300);
    check("bright_old_an", an_o, 32'hD);
    run_to(383);
    check("b4_frame", frame_o, 32'h1);
    check("b4_ack_early", update_ack_o, 32'h0);
    run_to(384);
    check("b4_ack", update_ack_o, 32'h1);
    check("b4_prev_slot_an", an_o, 32'h7);
    clear_stats();
    run_to(387);
    check("b4_first_lit", an_o, 32'hE);
    run_to(395);
    check("b4_ph5_dark", an_o, 32'hF);
    run_to(416);
    check("b4_d0_lit", hist[14], 32'd8);
    check("b4_d0_dark", hist[15], 32'd24);
    clear_stats();
    run_to(420);
    brightness_i = 4'd0;
    update_i     = 1'b1;
    run_to(421);
    update_i = 1'b0;
    run_to(448);
    check("b4_d1_lit", hist[13], 32'd8);
    run_to(512);
    check("b0_ack", update_ack_o, 32'h1);
    clear_stats();
    run_to(640);
    check("b0_all_dark", hist[15], 32'd128);

    // 4. frame-boundary update
    run_to(641);
    brightness_i = 4'd15;
    update_i     = 1'b1;
    run_to(642);
    update_i = 1'b0;
    run_to(799);
    clear_stats();
    run_to(800);
    digits_i = 32'h0000_FFFF;
    update_i = 1'b1;
    check("fb_old_d0", seg_o, 32'h79);
    run_to(801);
    update_i = 1'b0;
    run_to(810);
    update_i = 1'b1;
    run_to(811);
    update_i = 1'b0;
    run_to(835);
    check("fb_old_d2", seg_o, 32'h30);
    run_to(867);
    check("fb_old_d3", seg_o, 32'h19);
    run_to(895);
    check("fb_frame", frame_o, 32'h1);
    check("fb_ack_early", update_ack_o, 32'h0);
    run_to(896);
    check("fb_ack", update_ack_o, 32'h1);
    run_to(899);
    check("fb_new_d0_an", an_o, 32'hE);
    check("fb_new_d0_seg", seg_o, 32'h0E);
    run_to(931);
    check("fb_new_d1_an", an_o, 32'hD);
    check("fb_new_d1_seg", seg_o, 32'h0E);
    check("fb_single_ack", ack_cnt, 32'd1);

    // 5. masking and decimal point
    digit_en_i = 8'h05;
    dp_i       = 8'h02;
    update_i   = 1'b1;
    run_to(932);
    update_i = 1'b0;
    run_to(1024);
    check("mask_ack", update_ack_o, 32'h1);
    clear_stats();
    run_to(1060);
    check("mask_d1_dark", an_o, 32'hF);
    run_to(1090);
    check("mask_d2_ph0", an_o, 32'hF);
    run_to(1091);
    check("mask_d2_an", an_o, 32'hB);
    run_to(1151);
    check("mask_frame", frame_o, 32'h1);
    run_to(1152);
    check("mask_cnt_d0", hist[14], 32'd30);
    check("mask_cnt_d1", hist[13], 32'd0);
    check("mask_cnt_d2", hist[11], 32'd30);
    check("mask_cnt_d3", hist[7], 32'd0);
    check("mask_cnt_dark", hist[15], 32'd68);
    check("mask_dp_off", dp_lit, 32'd0);

    // 6. disable mid-slot, re-enable, reset mid-scan
    run_to(1170);
    check("dis_before", an_o, 32'hE);
    enable_i = 1'b0;
    run_to(1171);
    check("dis_an", an_o, 32'hF);
    check("dis_seg", seg_o, 32'h7F);
    run_to(1180);
    check("dis_held", an_o, 32'hF);
    enable_i = 1'b1;
    run_to(1183);
    check("reen_ph0", an_o, 32'hF);
    run_to(1184);
    check("reen_d0_an", an_o, 32'hE);
    check("reen_d0_seg", seg_o, 32'h0E);
    run_to(1307);
    check("reen_frame_early", frame_o, 32'h0);
    run_to(1308);
    check("reen_frame", frame_o, 32'h1);
    run_to(1320);
    check("pre_rst_an", an_o, 32'hE);
    rst_n = 1'b0;
    #1;
    check("async_rst_an", an_o, 32'hF);
    check("async_rst_seg", seg_o, 32'h7F);
    check("async_rst_dp", dp_o, 32'h1);
    run_to(1322);
    check("rst_hold_an", an_o, 32'hF);
    rst_n = 1'b1;

    // load requested while scanning, then enable drops before the frame ends
    base = cyc_n;
    run_to(base + 10);
    digits_i   = 32'h0000_4321;
    digit_en_i = 8'h0F;
    dp_i       = 8'h00;
    update_i   = 1'b1;
    run_to(base + 11);
    update_i = 1'b0;
    enable_i = 1'b0;
    check("pend_dis_ack0", update_ack_o, 32'h0);
    run_to(base + 12);
    check("pend_dis_ack1", update_ack_o, 32'h0);
    run_to(base + 13);
    check("pend_dis_ack", update_ack_o, 32'h1);
    enable_i = 1'b1;
    run_to(base + 16);
    check("pend_ph0", an_o, 32'hF);
    run_to(base + 17);
    check("pend_d0_an", an_o, 32'hE);
    check("pend_d0_seg", seg_o, 32'h79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
